alarm_uart_tx: RTL and testbench
================================

# alarm_uart_tx

Serial event reporter for the home controller: watches the alarm/status flags produced by the sensor blocks (burglar, fire, rain, water, window shatter, visitor, etc.) and transmits one UART 8N1 byte per new event to the wall panel / gateway. It is the transmit end of the panel link: sensors come in, and this block sends them out. Rising edges are captured, de-duplicated, queued in a small FIFO and serialized with a programmable baud divider.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- FIFO_DEPTH, default 4: event bytes buffered ahead of the transmitter. Power of two.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- events  in  8  level flags from alarm blocks; bit i = source i. Synchronous to clk.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while any event is pending, queued, or in flight.
- overflow  out  1  sticky; set when an event edge is merged into an already-pending one.

## Operation
- Edge capture: register ev_q. Edge on bit i = events[i] & ~ev_q[i]. ev_q resets to 8'hFF, so flags already high at reset release are not reported.
- Pending: 8-bit set. Edge on bit i sets pending[i]. An edge on a bit already pending sets overflow and produces no duplicate.
- Arbiter: each cycle, if pending is nonzero and the FIFO is not full, the lowest-index pending bit i is cleared and byte 8'h40 | i (ASCII '@'..'G') is written. When the FIFO is full, pending holds and no event is lost.
- A bit cleared by the arbiter in the same cycle its new edge arrives stays set as a fresh pending event. overflow is not set in that case.
- TX FSM states: IDLE, START, DATA, STOP (PARITY with the macro enabled).
  - IDLE: if the FIFO is not empty, pop into shift register, load bit counter 0, and go to START. Otherwise stay.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is registered; tx=1 in IDLE.
- busy = (state != IDLE) | fifo_not_empty | (pending != 0).
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state entry. Width is $clog2(CLKS_PER_BIT).

## Timing
- Reset values: tx=1, busy=0, overflow=0. FSM=IDLE, FIFO empty, pending=0, ev_q=8'hFF.
- Reset mid-frame aborts the frame: tx=1 after the reset edge and all queued events are discarded.
- Latency:
  - Edge sampled at clock edge k sets pending at k.
  - FIFO write at k+1.
  - Pop, with tx falling, at k+2 if the FSM was IDLE.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity). Back-to-back frames have exactly one extra idle-high cycle (the IDLE visit) between the end of STOP and the next START.
- Simultaneous edges on several bits are sent in ascending index order, one FIFO write per cycle.
- FIFO read and write in the same cycle are legal at any fill level. A write while full is never issued.

## Configuration
- ALARM_UART_PARITY_EN defined: a PARITY state between DATA and STOP sends the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame is 11 bits.
- ALARM_UART_PARITY_EN undefined: no PARITY state; 8N1 frame of 10 bits.

## Structure
- Shared package home_pkg holds:
  - TX state enum (tx_state_t)
  - EVT_BASE = 8'h40
  - source index constants (EVT_BURGLAR=0, EVT_FIRE=1, EVT_RAIN=2, EVT_WATER=3, EVT_WINDOW=4, EVT_VISITOR=5)
- One sub-module: event_fifo, a synchronous FIFO with parameter FIFO_DEPTH and ports clk, reset, wr_en, din[7:0], rd_en, dout[7:0], full, empty.

## Test plan
Run with CLKS_PER_BIT=4.
- Single event: events[2] 0→1 at edge 10 → tx falls after edge 12. Frame carries 0x42 LSB first (0,1,0,0,0,0,1,0), then stop high. Total 40 cycles. busy drops after STOP completes.
- Simultaneous edges: events[5] and events[0] rise at the same edge → frames 0x40 then 0x45. One idle-high cycle between frames. overflow stays 0.
- FIFO full: six distinct bits rise one per cycle while tx is idle → all six bytes are sent in ascending order with no loss. Pending holds while the FIFO is full.
- Overflow: events[1] toggles 0→1→0→1 while bit 1 is still pending → a single 0x41 is sent and overflow=1 until reset.
- Reset mid-frame: reset low during DATA bit 3 → tx=1 and busy=0 after that edge. events held high through release → no frame is sent.
- Parity build: with ALARM_UART_PARITY_EN, events[3] rises → 0x43 frame with parity bit 1, 44 cycles total.

Source files
------------

// File: rtl/home_pkg.sv
// Shared home-controller definitions: UART transmitter states, event byte base and sensor source indices.
package home_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3,
    TX_PARITY = 3'd4
  } tx_state_t;

  localparam logic [7:0] EVT_BASE = 8'h40;

  localparam int EVT_BURGLAR = 0;
  localparam int EVT_FIRE    = 1;
  localparam int EVT_RAIN    = 2;
  localparam int EVT_WATER   = 3;
  localparam int EVT_WINDOW  = 4;
  localparam int EVT_VISITOR = 5;

endpackage

// File: rtl/alarm_uart_tx_fifo.sv
// event_fifo: small synchronous byte FIFO between the event arbiter and the UART shifter.
// dout always shows the head entry so a pop can load it in the same cycle.
module event_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alarm_uart_tx.sv
// alarm_uart_tx: captures rising edges of alarm flags and sends one UART byte ('@'+index) per event.
// Define ALARM_UART_PARITY_EN to append an even parity bit (8E1 frame, 11 bits).
module alarm_uart_tx
  import home_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] events,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = TX_IDLE;
  localparam logic [2:0] START  = TX_START;
  localparam logic [2:0] DATA   = TX_DATA;
  localparam logic [2:0] STOP   = TX_STOP;
`ifdef ALARM_UART_PARITY_EN
  localparam logic [2:0] PARITY = TX_PARITY;
`endif

  logic [7:0]    ev_q;
  logic [7:0]    rise;
  logic [7:0]    pending;
  logic [7:0]    grant;
  logic [2:0]    grant_idx;
  logic          wr_en;
  logic [7:0]    din;
  logic          rd_en;
  logic [7:0]    dout;
  logic          full;
  logic          empty;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    data;

  assign rise = events & ~ev_q;

  // Lowest-index pending bit wins; nothing is granted while the FIFO is full.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (!full) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending[i]) begin
          grant        = '0;
          grant[i]     = 1'b1;
          grant_idx    = 3'(i);
        end
      end
    end
  end

  assign wr_en = |grant;
  assign din   = EVT_BASE | {5'b0, grant_idx};

  // A new edge on a bit being granted this cycle re-arms it rather than counting as overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ev_q     <= 8'hFF;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      ev_q     <= events;
      pending  <= (pending & ~grant) | rise;
      overflow <= overflow | (|(rise & pending & ~grant));
    end
  end

  event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr_en(wr_en),
    .din  (din),
    .rd_en(rd_en),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  assign rd_en = (state == IDLE) && !empty;
  assign busy  = (state != IDLE) || !empty || (pending != 8'h00);

  // tx is updated on each transition so it always reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_cnt <= '0;
      data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            data    <= dout;
            bit_cnt <= '0;
            baud    <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= data[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef ALARM_UART_PARITY_EN
              tx    <= ^data;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= data[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef ALARM_UART_PARITY_EN
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_uart_tx.sv
// Bench for alarm_uart_tx: a UART monitor decodes frames from tx and checks them against a queue of expected bytes.
// Honours ALARM_UART_PARITY_EN for the frame length and parity bit.
module tb_alarm_uart_tx;
  import home_pkg::*;

  localparam int CPB = 4;
`ifdef ALARM_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] events = 8'h00;
  logic       tx;
  logic       busy;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frames = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [7:0] exp_q [$];

  alarm_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .events  (events),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ev);
    @(negedge clk);
    events = ev;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Frame decoder: samples each bit in its middle; a reset during the frame discards it.
  always begin : monitor
    logic [7:0] byte_v;
    logic       ok;
    logic       stop_v;
    logic       par_v;
    logic [7:0] e;
    int         s;
    @(negedge clk);
    if (reset && !tx) begin
      s  = cyc;
      ok = 1'b1;
      par_v = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (!reset) ok = 1'b0;
      end
      if (ok) checkOutput("start_bit", 32'(tx), 32'd0);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) begin
          @(negedge clk);
          if (!reset) ok = 1'b0;
        end
        byte_v[j] = tx;
      end
`ifdef ALARM_UART_PARITY_EN
      repeat (CPB) begin
        @(negedge clk);
        if (!reset) ok = 1'b0;
      end
      par_v = tx;
`endif
      repeat (CPB) begin
        @(negedge clk);
        if (!reset) ok = 1'b0;
      end
      stop_v = tx;
      if (ok) begin
        checkOutput("stop_bit", 32'(stop_v), 32'd1);
        checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("frame_byte", 32'(byte_v), 32'(e));
`ifdef ALARM_UART_PARITY_EN
          checkOutput("parity_bit", 32'(par_v), 32'(^e));
`endif
        end
        prev_start = last_start;
        last_start = s;
        frames++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base_frames;
    logic [7:0] ev;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_busy", 32'(busy), 32'd0);

    // Single event: latency, frame length, busy drop
    $display("[TB] single event");
    applyStimulus(8'h01 << EVT_RAIN);
    exp_q.push_back(EVT_BASE | 8'(EVT_RAIN));
    @(negedge clk);
    checkOutput("lat_k_busy", 32'(busy), 32'd1);
    checkOutput("lat_k_tx", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("lat_k1_tx", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("lat_k2_tx", 32'(tx), 32'd0);
    repeat (FRAME - 1) @(negedge clk);
    checkOutput("frame_end_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("after_frame_busy", 32'(busy), 32'd0);
    checkOutput("after_frame_tx", 32'(tx), 32'd1);
    waitIdle("single", 200);

    // Simultaneous edges: ascending order, one idle cycle between frames
    $display("[TB] simultaneous edges");
    applyStimulus(8'h00);
    applyStimulus((8'h01 << EVT_VISITOR) | (8'h01 << EVT_BURGLAR));
    exp_q.push_back(EVT_BASE | 8'(EVT_BURGLAR));
    exp_q.push_back(EVT_BASE | 8'(EVT_VISITOR));
    waitIdle("simul", 400);
    checkOutput("simul_gap", 32'(last_start - prev_start), 32'(FRAME + 1));
    checkOutput("simul_overflow", 32'(overflow), 32'd0);

    // FIFO full: six bits rising one per cycle
    $display("[TB] fifo full");
    applyStimulus(8'h00);
    ev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ev = ev | (8'h01 << i);
      applyStimulus(ev);
      exp_q.push_back(EVT_BASE | 8'(i));
    end
    @(negedge clk);
    checkOutput("full_busy", 32'(busy), 32'd1);
    waitIdle("full", 1500);
    checkOutput("full_overflow", 32'(overflow), 32'd0);

    // Overflow: bit 1 re-triggers while still held pending behind a full FIFO
    $display("[TB] overflow");
    applyStimulus(8'h00);
    applyStimulus(8'h3D);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h45);
    repeat (6) @(negedge clk);
    applyStimulus(8'h3F);
    checkOutput("ovf_before", 32'(overflow), 32'd0);
    applyStimulus(8'h3D);
    applyStimulus(8'h3F);
    exp_q.push_back(EVT_BASE | 8'(EVT_FIRE));
    @(negedge clk);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    waitIdle("ovf", 1500);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame during data bit 3
    $display("[TB] reset mid-frame");
    applyStimulus(8'h00);
    base_frames = frames;
    applyStimulus(8'h01 << EVT_WINDOW);
    repeat (3) @(negedge clk);
    checkOutput("rst_frame_started", 32'(tx), 32'd0);
    repeat (17) @(negedge clk);
    reset  = 1'b0;
    events = 8'hFF;
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    checkOutput("rst_no_frame", 32'(frames - base_frames), 32'd0);
    checkOutput("rst_idle_tx", 32'(tx), 32'd1);
    checkOutput("rst_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
